// File: rtl/strategy_risk_pipeline.sv
// Imbalance strategy with position, rate-window and kill-switch risk checks feeding a valid/ready action FIFO.
// Optional DEDUP_EN: reject an action repeating the last accepted {side,price} within the current rate window.
module strategy_risk_pipeline #(
    parameter int unsigned PRICE_W    = 32,
    parameter int unsigned QTY_W      = 32,
    parameter int unsigned SPREAD_MAX = 4,
    parameter int unsigned ORDER_QTY  = 1,
    parameter int unsigned MAX_POS    = 8,
    parameter int unsigned RATE_WIN   = 1024,
    parameter int unsigned RATE_MAX   = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    book_valid,
    input  logic [PRICE_W-1:0]      best_bid_price,
    input  logic [QTY_W-1:0]        best_bid_qty,
    input  logic [PRICE_W-1:0]      best_ask_price,
    input  logic [QTY_W-1:0]        best_ask_qty,
    input  logic                    kill_req,
    input  logic                    kill_clear,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_side,
    output logic [PRICE_W-1:0]      out_price,
    output logic [QTY_W-1:0]        out_qty,
    output logic signed [QTY_W+1:0] position,
    output logic                    throttled,
    output logic                    killed,
    output logic [31:0]             action_count,
    output logic [31:0]             reject_count
);

    localparam int unsigned POS_W = QTY_W + 2;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned WIN_W = $clog2(RATE_WIN);
    localparam int unsigned CNT_W = $clog2(RATE_MAX + 1);

    localparam logic [PRICE_W:0]         SPREAD_LIM = (PRICE_W + 1)'(SPREAD_MAX);
    localparam logic signed [POS_W-1:0]  STEP       = POS_W'(ORDER_QTY);
    localparam logic signed [POS_W-1:0]  POS_LIM    = POS_W'(MAX_POS);
    localparam logic [CNT_W-1:0]         CNT_LIM    = CNT_W'(RATE_MAX);
    localparam logic [PTR_W:0]           FIFO_LIM   = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_THROTTLED = 2'd1,
        ST_KILLED    = 2'd2
    } state_t;

    typedef struct packed {
        logic               side;
        logic [PRICE_W-1:0] price;
    } action_t;

    // Snapshot capture stage
    logic               s0_valid;
    logic [PRICE_W-1:0] s0_bid_price, s0_ask_price;
    logic [QTY_W-1:0]   s0_bid_qty, s0_ask_qty;

    // NOTE: every register uses non-blocking assignment so each stage sees the pre-edge value of the stage before it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid     <= 1'b0;
            s0_bid_price <= '0;
            s0_ask_price <= '0;
            s0_bid_qty   <= '0;
            s0_ask_qty   <= '0;
        end else begin
            s0_valid <= book_valid;
            if (book_valid) begin
                s0_bid_price <= best_bid_price;
                s0_ask_price <= best_ask_price;
                s0_bid_qty   <= best_bid_qty;
                s0_ask_qty   <= best_ask_qty;
            end
        end
    end

    // S1: imbalance decision; spread is taken one bit wider so a crossed book cannot alias to a small spread.
    logic [PRICE_W:0] spread;
    logic             dec_buy, dec_sell, dec_ok;
    logic             s1_valid;
    action_t          s1_act;

    always_comb begin
        spread   = {1'b0, s0_ask_price} - {1'b0, s0_bid_price};
        dec_buy  = s0_bid_qty > s0_ask_qty;
        dec_sell = s0_ask_qty > s0_bid_qty;
        dec_ok   = s0_valid && (s0_bid_qty != '0) && (s0_ask_qty != '0) &&
                   (s0_ask_price > s0_bid_price) && (spread <= SPREAD_LIM) &&
                   (dec_buy || dec_sell);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_act   <= '0;
        end else begin
            s1_valid     <= dec_ok;
            s1_act.side  <= dec_buy;
            s1_act.price <= dec_buy ? s0_ask_price : s0_bid_price;
        end
    end

    // S2: risk state, FIFO and window bookkeeping
    state_t           state, state_next;
    logic [WIN_W-1:0] rate_ctr;
    logic [CNT_W-1:0] win_count, win_count_next;
    logic             wrap;
    logic [PTR_W:0]   fifo_count;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    action_t          fifo_mem [FIFO_DEPTH];
    action_t          head;
    logic             fifo_full, pos_block, dedup_hit, reject, push, pop;

    assign wrap      = rate_ctr == WIN_W'(RATE_WIN - 1);
    assign throttled = win_count == CNT_LIM;
    assign killed    = state == ST_KILLED;
    assign fifo_full = fifo_count == FIFO_LIM;
    assign pos_block = s1_act.side ? (position + STEP > POS_LIM) : (position - STEP < -POS_LIM);

`ifdef DEDUP_EN
    logic    last_valid;
    action_t last_act;

    assign dedup_hit = last_valid && !wrap && (last_act == s1_act);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_valid <= 1'b0;
            last_act   <= '0;
        end else if (push) begin
            last_valid <= 1'b1;
            last_act   <= s1_act;
        end else if (wrap) begin
            last_valid <= 1'b0;
        end
    end
`else
    assign dedup_hit = 1'b0;
`endif

    // At a wrap the budget is fresh, so a full window count does not block an accept landing on the wrap edge.
    assign reject = s1_valid && (killed || kill_req || (throttled && !wrap) ||
                                 pos_block || fifo_full || dedup_hit);
    assign push   = s1_valid && !reject;
    assign pop    = out_valid && out_ready;

    // NOTE: defaults first in always_comb keep every path assigned, so no latches are inferred.
    always_comb begin
        win_count_next = win_count;
        state_next     = state;
        if (wrap)
            win_count_next = push ? CNT_W'(1) : '0;
        else if (push)
            win_count_next = win_count + 1'b1;

        case (state)
            ST_RUN:       if (win_count_next == CNT_LIM) state_next = ST_THROTTLED;
            ST_THROTTLED: if (wrap && win_count_next != CNT_LIM) state_next = ST_RUN;
            ST_KILLED:    if (kill_clear) state_next = ST_RUN;
            default:      state_next = ST_RUN;
        endcase
        if (kill_req)
            state_next = ST_KILLED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            rate_ctr     <= '0;
            win_count    <= '0;
            position     <= '0;
            action_count <= '0;
            reject_count <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
        end else begin
            state     <= state_next;
            rate_ctr  <= wrap ? '0 : rate_ctr + 1'b1;
            win_count <= win_count_next;
            if (push) begin
                position     <= s1_act.side ? position + STEP : position - STEP;
                action_count <= action_count + 32'd1;
                wr_ptr       <= wr_ptr + 1'b1;
            end
            if (reject)
                reject_count <= reject_count + 32'd1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // NOTE: FIFO storage is deliberately not reset; fifo_count alone decides which entries are visible.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= s1_act;
    end

    assign head      = fifo_mem[rd_ptr];
    assign out_valid = fifo_count != '0;
    assign out_side  = out_valid & head.side;
    assign out_price = out_valid ? head.price : '0;
    assign out_qty   = out_valid ? QTY_W'(ORDER_QTY) : '0;

endmodule

// File: tb/tb_strategy_risk_pipeline.sv
// Self-checking bench for strategy_risk_pipeline: vector table plus scoreboard-checked multi-cycle sequences.
module tb_strategy_risk_pipeline;

    localparam int RATE_WIN   = 64;
    localparam int RATE_MAX   = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int MAX_POS    = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               book_valid = 1'b0;
    logic [31:0]        best_bid_price = '0, best_bid_qty = '0;
    logic [31:0]        best_ask_price = '0, best_ask_qty = '0;
    logic               kill_req = 1'b0, kill_clear = 1'b0;
    logic               out_valid, out_side, out_ready = 1'b1;
    logic [31:0]        out_price, out_qty;
    logic signed [33:0] position;
    logic               throttled, killed;
    logic [31:0]        action_count, reject_count;

    strategy_risk_pipeline #(
        .PRICE_W(32), .QTY_W(32), .SPREAD_MAX(4), .ORDER_QTY(1), .MAX_POS(MAX_POS),
        .RATE_WIN(RATE_WIN), .RATE_MAX(RATE_MAX), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .book_valid(book_valid),
        .best_bid_price(best_bid_price), .best_bid_qty(best_bid_qty),
        .best_ask_price(best_ask_price), .best_ask_qty(best_ask_qty),
        .kill_req(kill_req), .kill_clear(kill_clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_side(out_side),
        .out_price(out_price), .out_qty(out_qty), .position(position),
        .throttled(throttled), .killed(killed),
        .action_count(action_count), .reject_count(reject_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        side;
        logic [31:0] price;
    } act_t;

    typedef struct {
        logic [31:0] bid_p, bid_q, ask_p, ask_q;
        bit          act;
        bit          side;
        logic [31:0] price;
    } vec_t;

    act_t sb_q[$];
    vec_t vecs[10];
    int   checks = 0, errors = 0;
    int   exp_pos = 0, exp_actions = 0, exp_rejects = 0;
    int   win_ctr = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Tracks where the design's free-running window counter is.
    always @(posedge clk) win_ctr <= rst ? 0 : ((win_ctr == RATE_WIN - 1) ? 0 : win_ctr + 1);

    // Scoreboard: each handshake is compared against the oldest expected action.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_output", 64'(out_price), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                act_t e;
                e = sb_q.pop_front();
                check("sb_side", 64'(out_side), 64'(e.side));
                check("sb_price", 64'(out_price), 64'(e.price));
                check("sb_qty", 64'(out_qty), 64'd1);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        sb_q.delete();
        exp_pos = 0; exp_actions = 0; exp_rejects = 0;
    endtask

    task automatic send(input logic [31:0] bp, bq, ap, aq);
        best_bid_price = bp; best_bid_qty = bq;
        best_ask_price = ap; best_ask_qty = aq;
        book_valid = 1'b1;
        idle(1);
        book_valid = 1'b0;
    endtask

    task automatic expect_act(input bit side, input logic [31:0] price);
        sb_q.push_back({side, price});
        exp_actions++;
        exp_pos += side ? 1 : -1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, "_actions"}, 64'(action_count), 64'(exp_actions));
        check({tag, "_rejects"}, 64'(reject_count), 64'(exp_rejects));
        check({tag, "_position"}, 64'(position), 64'(exp_pos));
    endtask

    task automatic wait_win(input int phase);
        int n = 0;
        while (win_ctr != phase && n < RATE_WIN + 2) begin
            idle(1);
            n++;
        end
        if (win_ctr != phase) begin
            checks++; errors++;
            $display("FAIL win_align timeout phase=%0d", phase);
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            idle(1);
            n++;
        end
        idle(2);
        check({tag, "_drained"}, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'd100, 32'd5, 32'd102, 32'd2, 1'b1, 1'b1, 32'd102};
        vecs[1] = '{32'd100, 32'd1, 32'd100, 32'd9, 1'b0, 1'b0, 32'd0};
        vecs[2] = '{32'd100, 32'd2, 32'd103, 32'd7, 1'b1, 1'b0, 32'd100};
        vecs[3] = '{32'd100, 32'd3, 32'd103, 32'd3, 1'b0, 1'b0, 32'd0};
        vecs[4] = '{32'd100, 32'd0, 32'd101, 32'd4, 1'b0, 1'b0, 32'd0};
        vecs[5] = '{32'd200, 32'd9, 32'd205, 32'd1, 1'b0, 1'b0, 32'd0};
        vecs[6] = '{32'd200, 32'd9, 32'd204, 32'd1, 1'b1, 1'b1, 32'd204};
        vecs[7] = '{32'd300, 32'd1, 32'd299, 32'd5, 1'b0, 1'b0, 32'd0};
        vecs[8] = '{32'hFFFF_FFFF, 32'd1, 32'd3, 32'd5, 1'b0, 1'b0, 32'd0};
        vecs[9] = '{32'd50, 32'd4, 32'd51, 32'd8, 1'b1, 1'b0, 32'd50};

        // Reset state
        do_reset();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_price", 64'(out_price), 64'd0);
        check("rst_throttled", 64'(throttled), 64'd0);
        check("rst_killed", 64'(killed), 64'd0);
        check_counts("rst");

        // Latency: book_valid in cycle N, out_valid first high in cycle N+3
        expect_act(1'b1, 32'd102);
        send(32'd100, 32'd5, 32'd102, 32'd2);
        check("lat_n1_valid", 64'(out_valid), 64'd0);
        idle(1);
        check("lat_n2_valid", 64'(out_valid), 64'd0);
        idle(1);
        check("lat_n3_valid", 64'(out_valid), 64'd1);
        check("lat_n3_position", 64'(position), 64'd1);
        drain("lat");

        // Vector table
        wait_win(0);
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].act) expect_act(vecs[i].side, vecs[i].price);
            send(vecs[i].bid_p, vecs[i].bid_q, vecs[i].ask_p, vecs[i].ask_q);
            idle(6);
            check_counts($sformatf("vec%0d", i));
        end
        drain("vec");

        // Rate window: 6 back-to-back buys, 4 accepted then throttled
        do_reset();
        wait_win(0);
        for (int i = 0; i < 6; i++) begin
            if (i < RATE_MAX) expect_act(1'b1, 32'(101 + i));
            else exp_rejects++;
            send(32'(100 + i), 32'd5, 32'(101 + i), 32'd1);
        end
        idle(3);
        check("rate_throttled", 64'(throttled), 64'd1);
        check_counts("rate");
        wait_win(0);
        check("rate_after_wrap", 64'(throttled), 64'd0);
        drain("rate");

        // FIFO full: consumer stalled, 6 snapshots over two windows
        do_reset();
        out_ready = 1'b0;
        wait_win(0);
        expect_act(1'b1, 32'd101); send(32'd100, 32'd5, 32'd101, 32'd1);
        expect_act(1'b0, 32'd100); send(32'd100, 32'd1, 32'd102, 32'd5);
        expect_act(1'b1, 32'd103); send(32'd101, 32'd5, 32'd103, 32'd1);
        idle(2);
        wait_win(0);
        expect_act(1'b1, 32'd104); send(32'd102, 32'd5, 32'd104, 32'd1);
        exp_rejects++;             send(32'd110, 32'd1, 32'd112, 32'd5);
        exp_rejects++;             send(32'd115, 32'd1, 32'd117, 32'd5);
        idle(3);
        check_counts("full");
        check("full_head", 64'(out_price), 64'd101);
        idle(3);
        check("full_head_stable", 64'(out_price), 64'd101);
        check("full_valid_stalled", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        drain("full");

        // Kill switch lands on the S2 edge of a snapshot
        send(32'd100, 32'd5, 32'd102, 32'd2);
        idle(1);
        kill_req = 1'b1;
        idle(1);
        kill_req = 1'b0;
        exp_rejects++;
        check("kill_killed", 64'(killed), 64'd1);
        check_counts("kill");
        exp_rejects++;
        send(32'd100, 32'd5, 32'd102, 32'd2);
        idle(4);
        check_counts("kill_hold");
        check("kill_no_output", 64'(out_valid), 64'd0);
        kill_clear = 1'b1;
        idle(1);
        kill_clear = 1'b0;
        check("kill_cleared", 64'(killed), 64'd0);
        expect_act(1'b0, 32'd90);
        send(32'd90, 32'd1, 32'd92, 32'd5);
        idle(4);
        check_counts("kill_resume");
        drain("kill");

        // Position limit: ninth buy blocked at +MAX_POS, a sell still passes
        do_reset();
        for (int i = 0; i < 9; i++) begin
            if (i % 3 == 0) wait_win(0);
            if (i < MAX_POS) expect_act(1'b1, 32'(101 + i));
            else exp_rejects++;
            send(32'(100 + i), 32'd5, 32'(101 + i), 32'd1);
            idle(1);
        end
        idle(3);
        check_counts("poslim");
        expect_act(1'b0, 32'd50);
        send(32'd50, 32'd1, 32'd51, 32'd5);
        idle(4);
        check_counts("poslim_sell");
        drain("poslim");

        // Reset mid-pipeline discards the in-flight snapshot
        send(32'd100, 32'd5, 32'd102, 32'd2);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        sb_q.delete();
        exp_pos = 0; exp_actions = 0; exp_rejects = 0;
        idle(5);
        check("midrst_valid", 64'(out_valid), 64'd0);
        check_counts("midrst");

        // Identical actions within one window, then after a wrap
        wait_win(0);
        expect_act(1'b1, 32'd102);
        send(32'd100, 32'd5, 32'd102, 32'd2);
        idle(1);
`ifdef DEDUP_EN
        exp_rejects++;
`else
        expect_act(1'b1, 32'd102);
`endif
        send(32'd100, 32'd5, 32'd102, 32'd2);
        idle(4);
        check_counts("dup_same_win");
        wait_win(0);
        expect_act(1'b1, 32'd102);
        send(32'd100, 32'd5, 32'd102, 32'd2);
        idle(4);
        check_counts("dup_next_win");
        drain("dup");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
